i2s_serial_mixer: RTL and testbench

//  Multi-input I2S stereo mixer, successor to the two-input serial adder.

---
 rtl/i2s_serial_mixer.sv | 147 ++++++++++++++
 tb/tb_i2s_serial_mixer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/i2s_serial_mixer.sv
// Multi-input I2S stereo mixer: deserialises NUM_IN MSB-first streams per
// ws slot, sums the enabled inputs as signed words with saturate/wrap, and
// replays each channel's result one frame later on sd_out. All state lives
// on the falling edge of sck.
module i2s_serial_mixer #(
  parameter int unsigned WIDTH    = 24,
  parameter int unsigned NUM_IN   = 2,
  parameter bit          SATURATE = 1'b1
) (
  input  logic              sck,
  input  logic              reset,
  input  logic              ws,
  input  logic [NUM_IN-1:0] sd_in,
  input  logic [NUM_IN-1:0] en,
  output logic              sd_out,
  output logic              clip
);

  localparam int unsigned SUM_W = WIDTH + $clog2(NUM_IN);
  localparam int unsigned EXT_W = SUM_W - WIDTH;
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MSB_PTR = {1'b1, {(WIDTH-1){1'b0}}};

  // Slot tracking
  logic ws_d;
  logic synced;

  // Capture: one-hot pointer selects the bit position the next sample lands in;
  // it runs out after WIDTH bits so later bits are ignored, and an early slot
  // edge leaves the unreceived LSBs at zero.
  logic [WIDTH-1:0] cap_ptr;
  logic [WIDTH-1:0] cap [NUM_IN];

  // Per-channel mix results, replayed in the next slot of the same channel
  logic [WIDTH-1:0] res_l;
  logic [WIDTH-1:0] res_r;
  logic             ovf_l;
  logic             ovf_r;

  // Transmit shifter; zeros shift in so the line idles low after WIDTH bits
  logic [WIDTH-1:0] tx_sh;

  // Combinational helpers
  logic             slot_edge_c;
  logic [SUM_W-1:0] mix_sum_c;
  logic [EXT_W:0]   mix_top_c;
  logic             mix_ovf_c;
  logic [WIDTH-1:0] mix_res_c;
  logic [WIDTH-1:0] ld_res_c;
  logic             ld_ovf_c;

  assign slot_edge_c = ws ^ ws_d;

  // Signed sum of enabled captured words, sign-extended to the full sum width
  always_comb begin
    mix_sum_c = '0;
    for (int i = 0; i < int'(NUM_IN); i++) begin
      if (en[i]) begin
        mix_sum_c = mix_sum_c + {{EXT_W{cap[i][WIDTH-1]}}, cap[i]};
      end
    end
  end

  // Overflow when the bits above the result sign bit disagree with it
  always_comb begin
    mix_top_c = mix_sum_c[SUM_W-1:WIDTH-1];
    mix_ovf_c = !((~|mix_top_c) || (&mix_top_c));
    mix_res_c = mix_sum_c[WIDTH-1:0];
    if (SATURATE && mix_ovf_c) begin
      mix_res_c = mix_sum_c[SUM_W-1] ? MAX_NEG : MAX_POS;
    end
  end

  // Result selected for the slot that is starting (channel = current ws)
  always_comb begin
    ld_res_c = ws ? res_r : res_l;
    ld_ovf_c = ws ? ovf_r : ovf_l;
  end

  // Slot edge detection and sync flag
  always_ff @(negedge sck or posedge reset) begin
    if (reset) begin
      ws_d   <= 1'b0;
      synced <= 1'b0;
    end else begin
      ws_d <= ws;
      if (slot_edge_c) begin
        synced <= 1'b1;
      end
    end
  end

  // Deserialise each input; bits sampled at the slot edge belong to no word
  always_ff @(negedge sck or posedge reset) begin
    if (reset) begin
      cap_ptr <= '0;
      for (int i = 0; i < int'(NUM_IN); i++) begin
        cap[i] <= '0;
      end
    end else if (slot_edge_c) begin
      cap_ptr <= MSB_PTR;
      for (int i = 0; i < int'(NUM_IN); i++) begin
        cap[i] <= '0;
      end
    end else begin
      cap_ptr <= cap_ptr >> 1;
      for (int i = 0; i < int'(NUM_IN); i++) begin
        cap[i] <= cap[i] | (sd_in[i] ? cap_ptr : '0);
      end
    end
  end

  // Store the mix of the slot that just ended; the pre-sync slot is discarded
  always_ff @(negedge sck or posedge reset) begin
    if (reset) begin
      res_l <= '0;
      res_r <= '0;
      ovf_l <= 1'b0;
      ovf_r <= 1'b0;
    end else if (slot_edge_c && synced) begin
      if (ws_d) begin
        res_r <= mix_res_c;
        ovf_r <= mix_ovf_c;
      end else begin
        res_l <= mix_res_c;
        ovf_l <= mix_ovf_c;
      end
    end
  end

  // Serialise the stored result MSB first; a slot edge aborts and reloads
  always_ff @(negedge sck or posedge reset) begin
    if (reset) begin
      tx_sh  <= '0;
      sd_out <= 1'b0;
      clip   <= 1'b0;
    end else if (slot_edge_c) begin
      tx_sh <= ld_res_c;
      clip  <= ld_ovf_c;
    end else begin
      sd_out <= tx_sh[WIDTH-1];
      tx_sh  <= {tx_sh[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: tb/tb_i2s_serial_mixer.sv
// Randomised bench for i2s_serial_mixer: a saturating and a wrapping instance
// share stimulus and are compared against a frame-level arithmetic model.
module tb_i2s_serial_mixer;

  localparam int unsigned WIDTH  = 24;
  localparam int unsigned NUM_IN = 2;
  localparam longint      MAXV   = (longint'(1) << (WIDTH - 1)) - 1;
  localparam longint      MINV   = -(longint'(1) << (WIDTH - 1));

  logic              sck = 1'b0;
  logic              reset;
  logic              ws;
  logic [NUM_IN-1:0] sd_in;
  logic [NUM_IN-1:0] en;
  logic              sd_out_s, clip_s;
  logic              sd_out_w, clip_w;

  int n_vec = 0;
  int n_err = 0;

  // Model state: per-channel expected results and the slot awaiting its end
  bit          m_synced = 1'b0;
  logic [23:0] m_res_s [2];
  logic [23:0] m_res_w [2];
  bit          m_ovf   [2];
  bit          p_ch;
  logic [23:0] p_w0, p_w1;
  logic [1:0]  p_en;

  i2s_serial_mixer #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SATURATE(1'b1)) dut_sat (
    .sck(sck), .reset(reset), .ws(ws), .sd_in(sd_in), .en(en),
    .sd_out(sd_out_s), .clip(clip_s)
  );

  i2s_serial_mixer #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SATURATE(1'b0)) dut_wrap (
    .sck(sck), .reset(reset), .ws(ws), .sd_in(sd_in), .en(en),
    .sd_out(sd_out_w), .clip(clip_w)
  );

  always #5 sck = ~sck;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
    end
  endtask

  function automatic longint sx(input logic [23:0] w);
    longint v;
    v = longint'(w);
    if (w[23]) v = v - (longint'(1) << WIDTH);
    return v;
  endfunction

  // Close the pending slot: plain signed arithmetic on the received words
  task automatic slot_end();
    longint s;
    bit     o;
    logic [63:0] u;
    s = 0;
    if (p_en[0]) s = s + sx(p_w0);
    if (p_en[1]) s = s + sx(p_w1);
    o = (s > MAXV) || (s < MINV);
    u = 64'(s);
    m_res_w[p_ch] = u[23:0];
    m_res_s[p_ch] = o ? ((s > 0) ? 24'h7FFFFF : 24'h800000) : u[23:0];
    m_ovf[p_ch]   = o;
  endtask

  task automatic model_reset();
    m_synced = 1'b0;
    for (int c = 0; c < 2; c++) begin
      m_res_s[c] = '0;
      m_res_w[c] = '0;
      m_ovf[c]   = 1'b0;
    end
  endtask

  // One ws slot of len sck: drive words MSB first, collect both outputs
  task automatic run_slot(input bit ch, input int len, input logic [23:0] w0,
                          input logic [23:0] w1, input logic [1:0] env, input int rst_at);
    logic [23:0] e_s, e_w, g_s, g_w, msk, ones, s0, s1;
    bit          e_c, g_cs, g_cw, t_s, t_w, live;
    int          nb;
    if (m_synced) slot_end();
    m_synced = 1'b1;
    e_s = m_res_s[ch];
    e_w = m_res_w[ch];
    e_c = m_ovf[ch];
    nb   = (len - 1 < int'(WIDTH)) ? len - 1 : int'(WIDTH);
    ones = '1;
    msk  = ~(ones >> nb);
    p_ch = ch;
    p_w0 = w0 & msk;
    p_w1 = w1 & msk;
    p_en = env;
    g_s = '0; g_w = '0; g_cs = 1'b0; g_cw = 1'b0; t_s = 1'b0; t_w = 1'b0;
    live = 1'b1;
    for (int n = 0; n < len; n++) begin
      if (reset) reset = 1'b0;
      if (n == rst_at) begin
        reset = 1'b1;
        #1;
        check_val("rst_sd_out_sat", 32'(sd_out_s), 32'd0);
        check_val("rst_clip_sat", 32'(clip_s), 32'd0);
        check_val("rst_sd_out_wrap", 32'(sd_out_w), 32'd0);
        check_val("rst_clip_wrap", 32'(clip_w), 32'd0);
        model_reset();
        live = 1'b0;
      end
      ws = ch;
      if (n >= 1 && n <= int'(WIDTH)) begin
        s0 = w0 << (n - 1);
        s1 = w1 << (n - 1);
        sd_in = {s1[23], s0[23]};
      end else begin
        sd_in = 2'($urandom);
      end
      if (n == 1) en = env;
      @(posedge sck);
      if (n == 0) begin
        g_cs = clip_s;
        g_cw = clip_w;
      end else if (n <= int'(WIDTH)) begin
        g_s = {g_s[22:0], sd_out_s};
        g_w = {g_w[22:0], sd_out_w};
      end else begin
        t_s = t_s | sd_out_s;
        t_w = t_w | sd_out_w;
      end
    end
    if (live) begin
      g_s = g_s << (int'(WIDTH) - nb);
      g_w = g_w << (int'(WIDTH) - nb);
      check_val(ch ? "word_sat_R" : "word_sat_L", 32'(g_s), 32'(e_s & msk));
      check_val(ch ? "word_wrap_R" : "word_wrap_L", 32'(g_w), 32'(e_w & msk));
      check_val("clip_sat", 32'(g_cs), 32'(e_c));
      check_val("clip_wrap", 32'(g_cw), 32'(e_c));
      if (len - 1 > int'(WIDTH)) begin
        check_val("tail_sat", 32'(t_s), 32'd0);
        check_val("tail_wrap", 32'(t_w), 32'd0);
      end
    end
  endtask

  function automatic logic [23:0] rand_word();
    logic [23:0] r;
    r = 24'($urandom);
    case ($urandom_range(0, 3))
      0: r = 24'h7FFFF0 | (r & 24'h00000F);
      1: r = 24'h800000 | (r & 24'h00000F);
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ch;
    model_reset();
    reset = 1'b1;
    ws    = 1'b0;
    sd_in = '0;
    en    = '0;
    repeat (3) @(posedge sck);
    #1;
    check_val("reset_sd_out_sat", 32'(sd_out_s), 32'd0);
    check_val("reset_clip_sat", 32'(clip_s), 32'd0);
    check_val("reset_sd_out_wrap", 32'(sd_out_w), 32'd0);
    check_val("reset_clip_wrap", 32'(clip_w), 32'd0);
    @(posedge sck);
    reset = 1'b0;

    run_slot(1'b1, 32, rand_word(), rand_word(), 2'b11, -1);
    run_slot(1'b0, 32, 24'h100000, 24'h200000, 2'b11, -1);
    run_slot(1'b1, 32, 24'h7FFFFF, 24'h000001, 2'b11, -1);
    run_slot(1'b0, 32, 24'h800000, 24'hFFFFFF, 2'b11, -1);
    run_slot(1'b1, 32, 24'h400000, 24'hC00000, 2'b11, -1);
    run_slot(1'b0, 32, 24'h123456, 24'h654321, 2'b01, -1);
    run_slot(1'b1, 32, 24'h123456, 24'h654321, 2'b00, -1);
    run_slot(1'b0, 32, rand_word(), rand_word(), 2'b11, -1);
    run_slot(1'b1, 17, 24'hABCDEF, 24'h000000, 2'b11, -1);
    run_slot(1'b0, 32, 24'h7FFFFF, 24'h7FFFFF, 2'b11, -1);
    run_slot(1'b1, 32, rand_word(), rand_word(), 2'b11, -1);
    run_slot(1'b0, 32, rand_word(), rand_word(), 2'b11, 20);
    run_slot(1'b1, 32, 24'h111111, 24'h222222, 2'b11, -1);
    run_slot(1'b0, 32, 24'h333333, 24'h111111, 2'b11, -1);
    run_slot(1'b1, 32, rand_word(), rand_word(), 2'b11, -1);
    run_slot(1'b0, 32, rand_word(), rand_word(), 2'b11, -1);

    ch = 1'b1;
    for (int s = 0; s < 40; s++) begin
      run_slot(ch, int'($urandom_range(20, 40)), rand_word(), rand_word(), 2'($urandom), -1);
      ch = ~ch;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
